// File: rtl/dm_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
// Read tags record who owns each in-flight read so the returning data can be steered back to it.
package dm_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWNER_CPU  = 1'b0,
        OWNER_HOST = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

endpackage

// File: rtl/dm_rd_tag_pipe.sv
// Delay line of read tags matching the RAM read latency.
// Its output marks which requester receives mem_read_data in the current cycle.
module dm_rd_tag_pipe
    import dm_arb_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic    clock,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t tag_r [READ_LATENCY];

    // Shift tags one stage per cycle; reset drops every in-flight read
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            tag_r[0] <= tag_in;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    assign tag_out = tag_r[READ_LATENCY-1];

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data RAM between the CPU data port and the host/debug port.
// Round-robin arbitration, host burst locking, and a starvation guard that forces the CPU through.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_WAIT     = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    arb_state_t state_r, next_state_s;
    owner_t     last_owner_r, next_owner_s;
    logic [7:0] wait_cnt_r, next_wait_s;
    logic       cpu_force_s;
    rd_tag_t    tag_in_s, tag_out_s;

    // Grant decision: forced CPU first, then a held host lock, otherwise round-robin
    always_comb begin
        cpu_gnt     = 1'b0;
        host_gnt    = 1'b0;
        cpu_force_s = cpu_req && (wait_cnt_r == MAX_WAIT_C);
        if (reset) begin
            cpu_gnt  = 1'b0;
            host_gnt = 1'b0;
        end else if (cpu_force_s) begin
            cpu_gnt = 1'b1;
        end else if ((state_r == LOCKED) && host_lock) begin
            host_gnt = host_req;
        end else if (cpu_req && host_req) begin
            if (last_owner_r == OWNER_HOST) begin
                cpu_gnt = 1'b1;
            end else begin
                host_gnt = 1'b1;
            end
        end else begin
            cpu_gnt  = cpu_req;
            host_gnt = host_req;
        end
    end

    // Next lock state, owner history and CPU wait counter
    always_comb begin
        next_state_s = state_r;
        next_owner_s = last_owner_r;
        next_wait_s  = wait_cnt_r;
        case (state_r)
            ARB:     next_state_s = (host_gnt && host_lock) ? LOCKED : ARB;
            LOCKED:  next_state_s = host_lock ? LOCKED : ARB;
            default: next_state_s = ARB;
        endcase
        if (cpu_gnt) begin
            next_owner_s = OWNER_CPU;
        end else if (host_gnt) begin
            next_owner_s = OWNER_HOST;
        end else begin
            next_owner_s = last_owner_r;
        end
        if (!cpu_req || cpu_gnt) begin
            next_wait_s = 8'd0;
        end else if (wait_cnt_r < MAX_WAIT_C) begin
            next_wait_s = wait_cnt_r + 8'd1;
        end else begin
            next_wait_s = wait_cnt_r;
        end
    end

    // Arbiter state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ARB;
            last_owner_r <= OWNER_HOST;
            wait_cnt_r   <= 8'd0;
        end else begin
            state_r      <= next_state_s;
            last_owner_r <= next_owner_s;
            wait_cnt_r   <= next_wait_s;
        end
    end

    // Route the granted requester onto the RAM ports and tag its reads
    always_comb begin
        mem_write_enable  = 1'b0;
        mem_write_address = '0;
        mem_write_data    = '0;
        mem_read_address  = '0;
        tag_in_s          = '0;
        if (cpu_gnt) begin
            if (cpu_we) begin
                mem_write_enable  = 1'b1;
                mem_write_address = cpu_addr;
                mem_write_data    = cpu_wdata;
            end else begin
                mem_read_address = cpu_addr;
                tag_in_s         = '{valid: 1'b1, owner: OWNER_CPU};
            end
        end else if (host_gnt) begin
            if (host_we) begin
                mem_write_enable  = 1'b1;
                mem_write_address = host_addr;
                mem_write_data    = host_wdata;
            end else begin
                mem_read_address = host_addr;
                tag_in_s         = '{valid: 1'b1, owner: OWNER_HOST};
            end
        end else begin
            tag_in_s = '0;
        end
    end

    dm_rd_tag_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_tag_pipe (
        .clock  (clock),
        .reset  (reset),
        .tag_in (tag_in_s),
        .tag_out(tag_out_s)
    );

    // Steer returning read data to its owner only
    always_comb begin
        cpu_rvalid  = 1'b0;
        host_rvalid = 1'b0;
        if (reset) begin
            cpu_rvalid  = 1'b0;
            host_rvalid = 1'b0;
        end else begin
            cpu_rvalid  = tag_out_s.valid && (tag_out_s.owner == OWNER_CPU);
            host_rvalid = tag_out_s.valid && (tag_out_s.owner == OWNER_HOST);
        end
        cpu_rdata  = cpu_rvalid  ? mem_read_data : '0;
        host_rdata = host_rvalid ? mem_read_data : '0;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Two-requester arbiter that shares the single-port data memory RAM between the CPU core's data port and a host/debug port used for program loading, inspection and result dump.
- Sits between the cpu and ram instances in the top level. The cpu's dm_* port connects to the cpu side; the ram's write/read port connects to the mem side.
- Provides a per-cycle request/grant handshake, round-robin fairness, host burst locking with CPU starvation protection, and routing of read data back to the owning requester.

Parameters:
- ADDR_W, 32, address width; matches ADDRESS_SIZE.
- DATA_W, 32, data width; matches DATA_SIZE.
- READ_LATENCY, 1, cycles from read acceptance to valid mem_read_data; legal range 1..4.
- MAX_WAIT, 4, consecutive denied CPU-request cycles tolerated before the CPU is forced through a host lock; legal range 1..255.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU transaction request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- host_req  in  1  host transaction request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_lock  in  1  host requests a locked burst.
- host_gnt  out  1  host request accepted this cycle.
- host_rvalid  out  1  host read data valid.
- host_rdata  out  DATA_W  host read data.
- mem_write_enable  out  1  to ram write_enable.
- mem_write_address  out  ADDR_W  to ram write_address.
- mem_write_data  out  DATA_W  to ram write_data.
- mem_read_address  out  ADDR_W  to ram read_address.
- mem_read_data  in  DATA_W  from ram read_data.

Behaviour:
- Clocking and reset:
  - One clock domain (clock). reset is synchronous and active-high.
  - While reset=1: state=ARB, last_owner=HOST, wait_cnt=0, read-tag pipeline cleared.
  - While reset=1: cpu_gnt=host_gnt=0, mem_write_enable=0, both rvalid=0, all data/address outputs 0.
- Transaction acceptance:
  - A transaction is accepted in a cycle where req=1 and gnt=1.
  - gnt is combinational from req, state and wait_cnt. At most one gnt is high per cycle.
- Write path:
  - For an accepted write, in the same cycle: mem_write_enable=1, mem_write_address=addr, mem_write_data=wdata.
  - Otherwise mem_write_enable=0 and mem_write_address/mem_write_data are 0.
- Read path:
  - For an accepted read, in the same cycle: mem_read_address=addr. Otherwise mem_read_address=0.
  - Exactly READ_LATENCY cycles later, the owner's rvalid=1 for one cycle and its rdata=mem_read_data.
  - The non-owner's rvalid=0 and its rdata=0.
  - Back-to-back reads from either requester are fully pipelined, one per cycle.
- Arbitration state ARB:
  - Only one requester asserts req: that requester is granted.
  - Both assert req: the requester that is not last_owner is granted.
  - last_owner updates on every grant.
  - A host grant with host_lock=1 moves the state to LOCKED next cycle.
- Arbitration state LOCKED:
  - host_gnt=host_req and cpu_gnt=0, except when the CPU is forced (see starvation).
  - If host_lock=0 in the current cycle, that cycle is arbitrated as ARB and the state returns to ARB next cycle.
- Starvation protection:
  - wait_cnt increments each cycle with cpu_req=1 and cpu_gnt=0, saturating at MAX_WAIT.
  - wait_cnt clears on a CPU grant or when cpu_req=0.
  - When wait_cnt==MAX_WAIT and cpu_req=1, the CPU is granted regardless of state and host_gnt=0.
  - The state is unchanged by a forced grant, so a lock survives it.
- Read/write ordering:
  - The RAM has one write per cycle; a write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
- Reset mid-operation:
  - In-flight reads are discarded; no rvalid is issued for them after reset.
- Unused fields:
  - cpu_we/host_we/addr/wdata are ignored when the matching req=0.
  - host_lock is ignored when host is not granted in ARB.

Decomposition:
- Shared package dm_arb_pkg holds:
  - typedef enum arb_state_t {ARB, LOCKED}.
  - typedef enum owner_t {OWNER_CPU, OWNER_HOST}.
  - typedef struct rd_tag_t {valid, owner_t owner}.
  - widths taken from defines.vh.
- One sub-module, dm_rd_tag_pipe: a READ_LATENCY-deep shift register of rd_tag_t, cleared on reset, whose output steers rvalid/rdata.

Test Plan:
- Reset: hold reset=1 for 3 cycles with both req=1 -> both gnt=0, mem_write_enable=0, rvalid=0. First cycle after release with both requesting -> cpu_gnt=1.
- Round-robin reads: preload mem[0x10]=0x11111111, mem[0x20]=0x22222222; both request reads continuously -> grants alternate C,H,C,H. One cycle after each grant the correct rvalid pulses with the matching data.
- Write-then-read: CPU writes 0x40=0xDEADBEEF in cycle N; host reads 0x40 in cycle N+1 -> host_rdata=0xDEADBEEF at N+2 and cpu_rvalid stays 0.
- Locked burst with starvation (MAX_WAIT=4): host writes 8 words to 0x100..0x11C with host_lock=1; CPU requests a read from the second burst cycle -> CPU is denied for 4 cycles, granted on the 5th, then the host burst resumes with the lock still held.
- Lock release: host drops host_lock with both requesting and last_owner=HOST -> cpu_gnt=1 that cycle, and the state is ARB next cycle.
- Reset mid-read: host read of 0x20 accepted in cycle N, reset=1 in cycle N+1 -> host_rvalid stays 0 through N+3.
